// File: rtl/dac_sample_feeder_if.sv
// Stream bundle around the DAC sample feeder.
//   Decoder side : s_valid / s_ready handshake carrying s_left / s_right PCM.
//   Codec side   : wr_dac_fifo strobe with dac_fifo_in data, gated by dac_fifo_full.
// Modports:
//   slave  - the feeder itself (consumes PCM, produces FIFO writes)
//   master - the surrounding environment (decoder plus codec FIFO)
interface dac_sample_feeder_if;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_left;
    logic [15:0] s_right;
    logic        wr_dac_fifo;
    logic [31:0] dac_fifo_in;
    logic        dac_fifo_full;

    modport slave (
        input  s_valid, s_left, s_right, dac_fifo_full,
        output s_ready, wr_dac_fifo, dac_fifo_in
    );

    modport master (
        output s_valid, s_left, s_right, dac_fifo_full,
        input  s_ready, wr_dac_fifo, dac_fifo_in
    );
endinterface

// File: rtl/dac_sample_feeder.sv
// DAC sample feeder: accepts decoded 16-bit stereo PCM over valid/ready,
// scales it by a click-free ramped gain, packs {L,R} and writes it into the
// codec DAC FIFO. Also tracks FIFO occupancy from sample_tick and counts
// underruns.
// Ports:
//   clk, reset_n    clock, asynchronous active-low reset
//   bus (slave)     decoder stream in, DAC FIFO write out
//   volume, mute    gain target (8'hFF = unity, mute ramps to 0)
//   sample_tick     codec consumed one FIFO entry (also steps the gain ramp)
//   clr_underrun    synchronous clear of underrun_count
//   underrun_count  saturating count of ticks that found the FIFO empty
//   fifo_level      tracked DAC FIFO occupancy
module dac_sample_feeder #(
    parameter int FIFO_SIZE = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    dac_sample_feeder_if.slave   bus,
    input  logic [7:0]           volume,
    input  logic                 mute,
    input  logic                 sample_tick,
    input  logic                 clr_underrun,
    output logic [15:0]          underrun_count,
    output logic [FIFO_SIZE:0]   fifo_level
);

    // Pipeline state: S1 holds the raw sample, S2 the scaled packed word.
    logic                 s1_valid_reg;
    logic [31:0]          s1_data_reg;
    logic                 s2_valid_reg;
    logic [31:0]          s2_data_reg;

    logic [8:0]           cur_gain_reg, cur_gain_next;
    logic [FIFO_SIZE:0]   fifo_level_reg, fifo_level_next;
    logic [15:0]          underrun_reg, underrun_next;

    logic                 wr;
    logic                 adv2;
    logic                 accept;
    logic [8:0]           tgt_gain;
    logic [31:0]          scaled_data;

    // Handshake: S2 drains into the FIFO, S1 drains into S2, so the input
    // stays ready as long as the pipeline can move.
    assign wr              = s2_valid_reg & ~bus.dac_fifo_full;
    assign adv2            = ~s2_valid_reg | wr;
    assign bus.s_ready     = ~s1_valid_reg | adv2;
    assign accept          = bus.s_valid & bus.s_ready;
    assign bus.wr_dac_fifo = wr;
    assign bus.dac_fifo_in = s2_data_reg;

    // Per-channel scaling. Gain is at most 256 so the signed product of a
    // 16-bit sample never overflows bits [23:8]; 256 is an exact passthrough.
    // gi = 1 is the left channel (upper half), gi = 0 the right.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_scale
            logic signed [25:0] product;
            logic               unused_bits;
            assign product = $signed(s1_data_reg[16*gi +: 16]) * $signed({1'b0, cur_gain_reg});
            assign scaled_data[16*gi +: 16] = product[23:8];
            assign unused_bits = ^{product[25:24], product[7:0]};
        end
    endgenerate

    // Gain ramp: one LSB per sample_tick toward the target avoids clicks.
    always_comb begin
        tgt_gain      = mute ? 9'd0 : ((volume == 8'hFF) ? 9'd256 : {1'b0, volume});
        cur_gain_next = cur_gain_reg;
        if (sample_tick) begin
            if (cur_gain_reg < tgt_gain)
                cur_gain_next = cur_gain_reg + 9'd1;
            else if (cur_gain_reg > tgt_gain)
                cur_gain_next = cur_gain_reg - 9'd1;
        end
    end

    // Occupancy and underrun tracking. A write and a tick in the same cycle
    // cancel out, even at level 0 (the codec reads the entry being written).
    always_comb begin
        fifo_level_next = fifo_level_reg;
        underrun_next   = underrun_reg;
        case ({wr, sample_tick})
            2'b10:   fifo_level_next = fifo_level_reg + 1'b1;
            2'b01:   if (fifo_level_reg != '0) fifo_level_next = fifo_level_reg - 1'b1;
            default: fifo_level_next = fifo_level_reg;
        endcase
        if (clr_underrun)
            underrun_next = 16'd0;
        else if (sample_tick && !wr && fifo_level_reg == '0 && underrun_reg != 16'hFFFF)
            underrun_next = underrun_reg + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_reg   <= 1'b0;
            s1_data_reg    <= 32'd0;
            s2_valid_reg   <= 1'b0;
            s2_data_reg    <= 32'd0;
            cur_gain_reg   <= 9'd0;
            fifo_level_reg <= '0;
            underrun_reg   <= 16'd0;
        end else begin
            if (adv2) begin
                s2_valid_reg <= s1_valid_reg;
                s2_data_reg  <= scaled_data;
            end
            if (accept) begin
                s1_valid_reg <= 1'b1;
                s1_data_reg  <= {bus.s_left, bus.s_right};
            end else if (adv2) begin
                s1_valid_reg <= 1'b0;
            end
            cur_gain_reg   <= cur_gain_next;
            fifo_level_reg <= fifo_level_next;
            underrun_reg   <= underrun_next;
        end
    end

    assign underrun_count = underrun_reg;
    assign fifo_level     = fifo_level_reg;

endmodule

// File: tb/tb_dac_sample_feeder.sv
module tb_dac_sample_feeder;
    logic        clk;
    logic        reset_n;
    logic [7:0]  volume;
    logic        mute;
    logic        sample_tick;
    logic        clr_underrun;
    logic [15:0] underrun_count;
    logic [3:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    dac_sample_feeder_if bus();

    dac_sample_feeder #(.FIFO_SIZE(3)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus            (bus),
        .volume         (volume),
        .mute           (mute),
        .sample_tick    (sample_tick),
        .clr_underrun   (clr_underrun),
        .underrun_count (underrun_count),
        .fifo_level     (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1. Advances one cycle with sample_tick high.
    task automatic tick();
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
    endtask

    // Called at posedge+1 with an empty pipeline and dac_fifo_full low.
    // Accept at edge N, write strobe visible only in the cycle after N+1.
    task automatic send(input string tag, input logic [15:0] l, input logic [15:0] r,
                        input logic [31:0] exp);
        bus.s_valid = 1'b1;
        bus.s_left  = l;
        bus.s_right = r;
        chk({tag, " ready"}, {31'd0, bus.s_ready}, 32'd1);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        chk({tag, " wr_early"}, {31'd0, bus.wr_dac_fifo}, 32'd0);
        @(posedge clk); #1;
        chk({tag, " wr"}, {31'd0, bus.wr_dac_fifo}, 32'd1);
        chk({tag, " data"}, bus.dac_fifo_in, exp);
        $display("send %s L=%h R=%h -> out=%h", tag, l, r, bus.dac_fifo_in);
        @(posedge clk); #1;
        chk({tag, " wr_once"}, {31'd0, bus.wr_dac_fifo}, 32'd0);
    endtask

    initial begin
        logic [15:0] g;
        reset_n           = 1'b1;
        volume            = 8'hFF;
        mute              = 1'b0;
        sample_tick       = 1'b0;
        clr_underrun      = 1'b0;
        bus.s_valid       = 1'b0;
        bus.s_left        = 16'd0;
        bus.s_right       = 16'd0;
        bus.dac_fifo_full = 1'b0;

        // Reset state, applied asynchronously before the first edge.
        #2 reset_n = 1'b0;
        #1;
        chk("rst s_ready", {31'd0, bus.s_ready}, 32'd1);
        chk("rst wr", {31'd0, bus.wr_dac_fifo}, 32'd0);
        chk("rst data", bus.dac_fifo_in, 32'd0);
        chk("rst level", {28'd0, fifo_level}, 32'd0);
        chk("rst underrun", {16'd0, underrun_count}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Unity gain: 300 ticks at level 0 saturate the ramp and all underrun.
        for (int i = 0; i < 300; i++) tick();
        chk("unity underrun", {16'd0, underrun_count}, 32'd300);
        send("unity", 16'h7FFF, 16'h8000, 32'h7FFF8000);
        chk("unity level", {28'd0, fifo_level}, 32'd1);

        // Half gain: ramp 256 -> 128; first tick drains the one entry.
        clr_underrun = 1'b1;
        @(posedge clk); #1;
        clr_underrun = 1'b0;
        chk("clr underrun", {16'd0, underrun_count}, 32'd0);
        volume = 8'h80;
        for (int i = 0; i < 128; i++) tick();
        chk("half underrun", {16'd0, underrun_count}, 32'd127);
        send("half", 16'h4000, 16'hC000, 32'h2000E000);

        // Backpressure with gain 128.
        bus.dac_fifo_full = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_left  = 16'h0200; bus.s_right = 16'h0400;
        chk("bp ready A", {31'd0, bus.s_ready}, 32'd1);
        @(posedge clk); #1;
        bus.s_left  = 16'h0600; bus.s_right = 16'h0800;
        chk("bp ready B", {31'd0, bus.s_ready}, 32'd1);
        @(posedge clk); #1;
        bus.s_left  = 16'h1000; bus.s_right = 16'hF000;
        chk("bp stall ready", {31'd0, bus.s_ready}, 32'd0);
        chk("bp stall wr", {31'd0, bus.wr_dac_fifo}, 32'd0);
        @(posedge clk); #1;
        chk("bp hold ready", {31'd0, bus.s_ready}, 32'd0);
        chk("bp hold wr", {31'd0, bus.wr_dac_fifo}, 32'd0);
        bus.dac_fifo_full = 1'b0;
        #1;
        chk("bp A wr", {31'd0, bus.wr_dac_fifo}, 32'd1);
        chk("bp A data", bus.dac_fifo_in, 32'h01000200);
        chk("bp release ready", {31'd0, bus.s_ready}, 32'd1);
        $display("bp out A=%h", bus.dac_fifo_in);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        chk("bp B wr", {31'd0, bus.wr_dac_fifo}, 32'd1);
        chk("bp B data", bus.dac_fifo_in, 32'h03000400);
        $display("bp out B=%h", bus.dac_fifo_in);
        @(posedge clk); #1;
        chk("bp C wr", {31'd0, bus.wr_dac_fifo}, 32'd1);
        chk("bp C data", bus.dac_fifo_in, 32'h0800F800);
        $display("bp out C=%h", bus.dac_fifo_in);
        @(posedge clk); #1;
        chk("bp drained", {31'd0, bus.wr_dac_fifo}, 32'd0);
        chk("bp level", {28'd0, fifo_level}, 32'd4);

        // Mute ramp from 256: every tick must drop the gain by exactly one.
        volume = 8'hFF;
        for (int i = 0; i < 128; i++) tick();
        send("gain256", 16'h0100, 16'h0100, 32'h01000100);
        mute = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            tick();
            g = 16'(256 - k);
            send("mute", 16'h0100, 16'h0100, {g, g});
        end
        tick();
        send("mute hold", 16'h0100, 16'h0100, 32'd0);

        // Underrun counting and clearing.
        tick();
        clr_underrun = 1'b1;
        @(posedge clk); #1;
        clr_underrun = 1'b0;
        chk("ur cleared", {16'd0, underrun_count}, 32'd0);
        chk("ur level0", {28'd0, fifo_level}, 32'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("ur five", {16'd0, underrun_count}, 32'd5);
        clr_underrun = 1'b1;
        tick();
        clr_underrun = 1'b0;
        chk("ur clr+tick", {16'd0, underrun_count}, 32'd0);
        bus.s_valid = 1'b1;
        bus.s_left  = 16'h1234; bus.s_right = 16'h5678;
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
        chk("wr+tick wr", {31'd0, bus.wr_dac_fifo}, 32'd1);
        tick();
        chk("wr+tick level", {28'd0, fifo_level}, 32'd0);
        chk("wr+tick underrun", {16'd0, underrun_count}, 32'd0);
        $display("write+tick at level 0: level=%0d underrun=%0d", fifo_level, underrun_count);

        // Reset mid-stream with both stages held by a full FIFO.
        for (int i = 0; i < 3; i++) tick();
        chk("pre-rst underrun", {16'd0, underrun_count}, 32'd3);
        bus.dac_fifo_full = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_left  = 16'h1111; bus.s_right = 16'h2222;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre-rst ready", {31'd0, bus.s_ready}, 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("mid rst ready", {31'd0, bus.s_ready}, 32'd1);
        chk("mid rst wr", {31'd0, bus.wr_dac_fifo}, 32'd0);
        chk("mid rst data", bus.dac_fifo_in, 32'd0);
        chk("mid rst underrun", {16'd0, underrun_count}, 32'd0);
        chk("mid rst level", {28'd0, fifo_level}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        bus.s_valid = 1'b0;
        bus.dac_fifo_full = 1'b0;
        @(posedge clk); #1;
        chk("post rst wr", {31'd0, bus.wr_dac_fifo}, 32'd0);
        @(posedge clk); #1;
        chk("post rst wr2", {31'd0, bus.wr_dac_fifo}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
